// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and helpers for the boot-time program loader
package loader_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        LOAD,
        CHK,
        RUN,
        ERR
    } loader_state_t;

    function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte stream to instruction memory, holds the core in reset until a good image lands
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MEM_BYTES = (1 << ADDR_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    loader_state_t state, stateNext;
    logic [LEN_W-1:0]  len, lenNext;
    logic [LEN_W-1:0]  cnt, cntNext;
    logic [7:0]        sum, sumNext;
    logic              weNext;
    logic [ADDR_W-1:0] addrNext;
    logic [7:0]        wdataNext;
    logic              xfer;
    logic [LEN_W-1:0]  lenFull;
    logic [LEN_W-1:0]  cntInc;

    assign xfer    = rx_valid && rx_ready;
    assign lenFull = {rx_data, len[7:0]};
    assign cntInc  = cnt + LEN_W'(1);

    always_comb begin
        stateNext = state;
        lenNext   = len;
        cntNext   = cnt;
        sumNext   = sum;
        weNext    = 1'b0;
        addrNext  = mem_addr;
        wdataNext = mem_wdata;
        if (reload) begin
            // Reload wins over any byte arriving in the same cycle.
            stateNext = LEN_LO;
            lenNext   = '0;
            cntNext   = '0;
            sumNext   = '0;
        end else if (xfer) begin
            unique case (state)
                LEN_LO: begin
                    lenNext   = {len[15:8], rx_data};
                    stateNext = LEN_HI;
                end
                LEN_HI: begin
                    lenNext = lenFull;
                    cntNext = '0;
                    sumNext = '0;
                    if ({1'b0, lenFull} > (LEN_W+1)'(MEM_BYTES))
                        stateNext = ERR;
                    else if (lenFull == '0)
                        stateNext = CHK;
                    else
                        stateNext = LOAD;
                end
                LOAD: begin
                    weNext    = 1'b1;
                    addrNext  = cnt[ADDR_W-1:0];
                    wdataNext = rx_data;
                    sumNext   = chk_add(sum, rx_data);
                    cntNext   = cntInc;
                    if (cntInc == len)
                        stateNext = CHK;
                end
                CHK: begin
                    stateNext = (rx_data == sum) ? RUN : ERR;
                end
                default: ;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LEN_LO;
            len       <= '0;
            cnt       <= '0;
            sum       <= '0;
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= stateNext;
            len       <= lenNext;
            cnt       <= cntNext;
            sum       <= sumNext;
            rx_ready  <= (stateNext != RUN) && (stateNext != ERR);
            mem_we    <= weNext;
            mem_addr  <= addrNext;
            mem_wdata <= wdataNext;
            cpu_rst   <= (stateNext != RUN);
            done      <= (stateNext == RUN);
            err       <= (stateNext == ERR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        reload;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [19:0] wrQ[$];

    program_loader #(.ADDR_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) wrQ.push_back({mem_addr, mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseReload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic checkTest1Writes(input string tag);
        logic [19:0] exp [4];
        exp[0] = {12'h000, 8'h13};
        exp[1] = {12'h001, 8'h05};
        exp[2] = {12'h002, 8'h50};
        exp[3] = {12'h003, 8'h00};
        check({tag, "_count"}, wrQ.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wrQ.size()) check($sformatf("%s_wr%0d", tag, i), {12'h0, wrQ[i]}, {12'h0, exp[i]});
        end
    endtask

    initial begin
        logic [7:0] bigSum;
        logic [7:0] bigData;
        int         bad;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        idle(2);

        // reset state
        check("rst_outputs", {rx_ready, mem_we, cpu_rst, done, err}, 5'b00100);
        check("rst_addr_data", {mem_addr, mem_wdata}, 20'h0);
        rst = 1'b1;
        idle(1);
        check("ready_after_rst", rx_ready, 1'b1);

        // test 1: good frame, back-to-back
        send(8'h04); send(8'h00);
        send(8'h13);
        check("t1_lat_we", {mem_we, mem_addr, mem_wdata}, {1'b1, 12'h000, 8'h13});
        send(8'h05); send(8'h50); send(8'h00);
        check("t1_hold_rst", {cpu_rst, done}, 2'b10);
        send(8'h68);
        check("t1_run", {cpu_rst, done, err, rx_ready}, 4'b0100);
        checkTest1Writes("t1");

        // test 2: bad checksum
        pulseReload();
        wrQ.delete();
        send(8'h04); send(8'h00); send(8'h13); send(8'h05); send(8'h50); send(8'h00);
        send(8'h69);
        check("t2_err", {err, cpu_rst, rx_ready, done}, 4'b1100);
        send(8'h11); send(8'h22); send(8'h33);
        idle(2);
        checkTest1Writes("t2");
        check("t2_err_hold", err, 1'b1);
        pulseReload();
        check("t2_reload", {err, rx_ready, cpu_rst}, 3'b011);

        // test 3a: oversize length
        wrQ.delete();
        send(8'h01); send(8'h10);
        check("t3_oversize_err", {err, rx_ready}, 2'b10);
        idle(2);
        check("t3_oversize_nowr", wrQ.size(), 0);

        // test 3b: full-capacity frame
        pulseReload();
        wrQ.delete();
        bigSum = 8'h00;
        send(8'h00); send(8'h10);
        for (int i = 0; i < 4096; i++) begin
            bigData = 8'((i * 37 + 5) & 255);
            bigSum  = bigSum + bigData;
            send(bigData);
        end
        check("t3_last_addr", {mem_we, mem_addr}, {1'b1, 12'hFFF});
        check("t3_before_chk", cpu_rst, 1'b1);
        send(bigSum);
        check("t3_done", {done, cpu_rst, err}, 3'b100);
        check("t3_count", wrQ.size(), 4096);
        bad = 0;
        for (int i = 0; i < wrQ.size(); i++) begin
            bigData = 8'((i * 37 + 5) & 255);
            if (wrQ[i] !== {12'(i), bigData}) bad++;
        end
        check("t3_contents", bad, 0);

        // test 4: empty frames
        pulseReload();
        wrQ.delete();
        send(8'h00); send(8'h00); send(8'h00);
        check("t4_empty_run", {done, cpu_rst, err}, 3'b100);
        pulseReload();
        send(8'h00); send(8'h00); send(8'h01);
        check("t4_empty_err", {done, cpu_rst, err}, 3'b011);
        check("t4_nowr", wrQ.size(), 0);

        // test 5: gaps in rx_valid
        pulseReload();
        wrQ.delete();
        begin
            logic [7:0] fr [7];
            fr[0] = 8'h04; fr[1] = 8'h00; fr[2] = 8'h13; fr[3] = 8'h05;
            fr[4] = 8'h50; fr[5] = 8'h00; fr[6] = 8'h68;
            for (int i = 0; i < 7; i++) begin
                idle($urandom_range(0, 3));
                send(fr[i]);
            end
        end
        check("t5_run", {done, cpu_rst}, 2'b10);
        checkTest1Writes("t5");

        // test 6: reload mid-load drops the concurrent byte
        pulseReload();
        wrQ.delete();
        send(8'h04); send(8'h00); send(8'h13); send(8'h05);
        rx_valid = 1'b1;
        rx_data  = 8'h50;
        reload   = 1'b1;
        @(posedge clk);
        #1;
        reload   = 1'b0;
        rx_valid = 1'b0;
        check("t6_reload_state", {mem_we, cpu_rst, rx_ready, done, err}, 5'b01100);
        idle(1);
        check("t6_dropped", wrQ.size(), 2);
        wrQ.delete();
        send(8'h02); send(8'h00); send(8'hAA); send(8'hBB); send(8'h65);
        check("t6_new_run", {done, cpu_rst}, 2'b10);
        check("t6_new_count", wrQ.size(), 2);
        if (wrQ.size() == 2) begin
            check("t6_new_wr0", {12'h0, wrQ[0]}, {12'h0, 12'h000, 8'hAA});
            check("t6_new_wr1", {12'h0, wrQ[1]}, {12'h0, 12'h001, 8'hBB});
        end

        // async reset mid-load
        pulseReload();
        send(8'h04); send(8'h00); send(8'h11); send(8'h22);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_outputs", {rx_ready, mem_we, cpu_rst, done, err}, 5'b00100);
        check("t6_async_addr_data", {mem_addr, mem_wdata}, 20'h0);
        idle(1);
        rst = 1'b1;
        idle(1);
        wrQ.delete();
        send(8'h04); send(8'h00); send(8'h13); send(8'h05); send(8'h50); send(8'h00); send(8'h68);
        check("t6_after_rst_run", {done, cpu_rst}, 2'b10);
        checkTest1Writes("t6r");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
